// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt controller for the 5-stage MIPS pipeline
module pipeline_ctrl #(
   parameter int MUL_LAT      = 4,
   parameter int DIV_LAT      = 12,
   parameter int MISS_TIMEOUT = 64,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_ID,
   input  logic [31:0]      inst_EX,
   input  logic [31:0]      inst_MEM,
   input  logic             hit,
   input  logic             branch_taken,
   input  logic             jump_ID,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles
);
   localparam int MW = $clog2(MISS_TIMEOUT + 1);
   typedef enum logic [1:0] {RUN, MD_BUSY, HALT} state_t;
   state_t           state_q, state_d;
   logic [7:0]       md_cnt_q, md_cnt_d;
   logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [5:0]       op_id, op_ex, op_mem;
   logic             load_ex, memop_mem, md_ex, syscall_mem, rt_used_id;
   logic             mem_stall, md_start, md_stall, load_use;
   logic [7:0]       lat_m1;
   logic             unused_bits;
   assign op_id       = inst_ID[31:26];
   assign op_ex       = inst_EX[31:26];
   assign op_mem      = inst_MEM[31:26];
   assign load_ex     = op_ex == 6'b100011 || op_ex == 6'b100000;
   assign memop_mem   = op_mem == 6'b100011 || op_mem == 6'b100000 || op_mem == 6'b101011 || op_mem == 6'b101000;
   assign md_ex       = op_ex == 6'b000000 && (inst_EX[5:0] == 6'b011000 || inst_EX[5:0] == 6'b011010);
   assign syscall_mem = op_mem == 6'b000000 && inst_MEM[5:0] == 6'b001100;
   assign rt_used_id  = op_id == 6'b000000 || op_id == 6'b000100 || op_id == 6'b000101 || op_id == 6'b101011 || op_id == 6'b101000;
   assign lat_m1      = inst_EX[1] ? 8'(DIV_LAT - 1) : 8'(MUL_LAT - 1);
   assign mem_stall   = memop_mem && !hit;
   assign md_start    = md_ex && lat_m1 != 8'd0;
   assign md_stall    = (state_q == RUN && md_start) || (state_q == MD_BUSY && md_cnt_q > 8'd1);
   assign load_use    = load_ex && inst_EX[20:16] != 5'd0 &&
                        (inst_EX[20:16] == inst_ID[25:21] || (rt_used_id && inst_EX[20:16] == inst_ID[20:16]));
   assign halted       = state_q == HALT;
   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;
   assign unused_bits  = ^{inst_ID[15:0], inst_EX[25:21], inst_EX[15:6], inst_EX[0], inst_MEM[25:6]};
   // Prioritised stall/flush generation; first matching hazard wins
   always_comb begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b1111;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b0000;
      if (rst || state_q == HALT) begin
         {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
         {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
      end else if (mem_stall) begin
         {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
         mem_wb_flush = 1'b1;
      end else if (branch_taken) begin
         {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
      end else if (md_stall) begin
         {pc_we, if_id_we, id_ex_we} = 3'b000;
         ex_mem_flush = 1'b1;
      end else if (load_use) begin
         {pc_we, if_id_we} = 2'b00;
         id_ex_flush = 1'b1;
      end else if (jump_ID) begin
         if_id_flush = 1'b1;
      end
   end
   // Next-state: MD sequencing, halt capture, miss timeout and stall counting
   always_comb begin
      state_d        = state_q;
      md_cnt_d       = md_cnt_q;
      miss_cnt_d     = miss_cnt_q;
      mem_timeout_d  = mem_timeout_q;
      stall_cycles_d = stall_cycles_q + CNT_W'(!pc_we && state_q != HALT);
      if (state_q != HALT) begin
         miss_cnt_d    = !mem_stall ? '0 : (miss_cnt_q == MW'(MISS_TIMEOUT) ? miss_cnt_q : miss_cnt_q + 1'b1);
         mem_timeout_d = mem_timeout_q || (mem_stall && miss_cnt_d == MW'(MISS_TIMEOUT));
         if (syscall_mem && !branch_taken) begin
            state_d  = HALT;
            md_cnt_d = '0;
         end else if (!mem_stall) begin
            if (branch_taken) begin
               state_d  = RUN;
               md_cnt_d = '0;
            end else if (state_q == RUN && md_start) begin
               state_d  = MD_BUSY;
               md_cnt_d = lat_m1;
            end else if (state_q == MD_BUSY) begin
               state_d  = md_cnt_q > 8'd1 ? MD_BUSY : RUN;
               md_cnt_d = md_cnt_q > 8'd1 ? md_cnt_q - 8'd1 : 8'd0;
            end
         end
      end
   end
   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         md_cnt_q       <= '0;
         miss_cnt_q     <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         md_cnt_q       <= md_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus with a per-cycle behavioural model of the hazard rules
module tb_pipeline_ctrl;
   localparam int MUL_LAT = 4, DIV_LAT = 12, TO = 64;
   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam logic [31:0] LW_R8    = {6'b100011, 5'd1, 5'd8, 16'd0};
   localparam logic [31:0] LW_R0    = {6'b100011, 5'd1, 5'd0, 16'd0};
   localparam logic [31:0] ADD_R8   = {6'd0, 5'd8, 5'd2, 5'd3, 5'd0, 6'b100000};
   localparam logic [31:0] ADD_R0   = {6'd0, 5'd0, 5'd2, 5'd3, 5'd0, 6'b100000};
   localparam logic [31:0] SW_RT8   = {6'b101011, 5'd2, 5'd8, 16'd0};
   localparam logic [31:0] ADDI_RT8 = {6'b001000, 5'd2, 5'd8, 16'd5};
   localparam logic [31:0] MULT     = {6'd0, 5'd1, 5'd2, 10'd0, 6'b011000};
   localparam logic [31:0] DIV      = {6'd0, 5'd1, 5'd2, 10'd0, 6'b011010};
   localparam logic [31:0] SW       = {6'b101011, 5'd1, 5'd9, 16'd0};
   localparam logic [31:0] SYSCALL  = 32'h0000_000C;

   logic clk = 1'b0;
   logic rst, hit, branch_taken, jump_ID;
   logic [31:0] inst_ID, inst_EX, inst_MEM;
   logic pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic halted, mem_timeout;
   logic [31:0] stall_cycles;
   logic [7:0] ctl;
   int tests = 0, fails = 0;

   int md_left = -1;
   bit m_halt = 0, m_tmo = 0;
   int m_miss = 0;
   logic [31:0] m_stalls = '0;

   pipeline_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .MISS_TIMEOUT(TO), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .inst_ID(inst_ID), .inst_EX(inst_EX), .inst_MEM(inst_MEM),
      .hit(hit), .branch_taken(branch_taken), .jump_ID(jump_ID),
      .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
      .mem_wb_flush(mem_wb_flush), .halted(halted), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles)
   );

   assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

   always #5 clk = ~clk;

   function automatic bit is_load(input logic [31:0] i);
      return i[31:26] == 6'b100011 || i[31:26] == 6'b100000;
   endfunction

   function automatic bit is_memop(input logic [31:0] i);
      return is_load(i) || i[31:26] == 6'b101011 || i[31:26] == 6'b101000;
   endfunction

   function automatic bit is_syscall(input logic [31:0] i);
      return i[31:26] == 6'd0 && i[5:0] == 6'b001100;
   endfunction

   function automatic int owed();
      if (md_left >= 0) return md_left;
      if (inst_EX[31:26] == 6'd0 && inst_EX[5:0] == 6'b011000) return MUL_LAT - 1;
      if (inst_EX[31:26] == 6'd0 && inst_EX[5:0] == 6'b011010) return DIV_LAT - 1;
      return 0;
   endfunction

   function automatic bit load_use();
      logic [4:0] rt;
      bit rt_read;
      rt = inst_EX[20:16];
      rt_read = inst_ID[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2b, 6'h28};
      return is_load(inst_EX) && rt != 5'd0 && (rt == inst_ID[25:21] || (rt_read && rt == inst_ID[20:16]));
   endfunction

   function automatic logic [7:0] exp_ctl();
      if (rst || m_halt) return 8'b0000_1111;
      if (is_memop(inst_MEM) && !hit) return 8'b0000_0001;
      if (branch_taken) return 8'b1111_1110;
      if (owed() > 0) return 8'b0001_0010;
      if (load_use()) return 8'b0011_0100;
      if (jump_ID) return 8'b1111_1000;
      return 8'b1111_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model advance: owed MD cycles, miss run, halt and stall count per cycle
   always @(posedge clk) begin
      logic [7:0] e;
      bit ms;
      int o;
      e = exp_ctl();
      o = owed();
      ms = is_memop(inst_MEM) && !hit;
      if (rst) begin
         m_halt <= 0; m_tmo <= 0; m_miss <= 0; m_stalls <= '0; md_left <= -1;
      end else if (!m_halt) begin
         if (!e[7]) m_stalls <= m_stalls + 1;
         m_miss <= ms ? (m_miss < TO ? m_miss + 1 : m_miss) : 0;
         if (ms && m_miss + 1 >= TO) m_tmo <= 1;
         if (is_syscall(inst_MEM) && !branch_taken) m_halt <= 1;
         if (!ms) md_left <= (branch_taken || md_left == 0 || o == 0) ? -1 : o - 1;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      chk("cyc_ctl", ctl, exp_ctl());
      chk("cyc_halted", halted, m_halt);
      chk("cyc_timeout", mem_timeout, m_tmo);
      chk("cyc_stalls", stall_cycles, m_stalls);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input logic [31:0] id, ex, mem, input logic h, bt, j);
      inst_ID = id; inst_EX = ex; inst_MEM = mem; hit = h; branch_taken = bt; jump_ID = j;
      #1;
   endtask

   task automatic md_run(input string name, input logic [31:0] ins, input int exp_n);
      int n;
      bit done;
      n = 0;
      done = 0;
      set(NOP, ins, NOP, 1, 0, 0);
      for (int k = 0; k < 300 && !done; k++) begin
         if (pc_we) done = 1;
         else n++;
         tick();
      end
      set(NOP, NOP, NOP, 1, 0, 0);
      chk(name, n, exp_n);
   endtask

   initial begin
      rst = 1;
      set(NOP, NOP, NOP, 1, 0, 0);
      chk("rst_ctl", ctl, 8'b0000_1111);
      repeat (2) tick();
      rst = 0;
      #1;
      chk("rst_halted", halted, 0);
      chk("rst_stalls", stall_cycles, 0);
      chk("run_ctl", ctl, 8'b1111_0000);
      set(ADD_R8, LW_R8, NOP, 1, 0, 0);
      chk("lu_rs", ctl, 8'b0011_0100);
      tick();
      set(NOP, NOP, NOP, 1, 0, 0);
      chk("lu_count", stall_cycles, 1);
      set(SW_RT8, LW_R8, NOP, 1, 0, 0);
      chk("lu_rt_sw", ctl, 8'b0011_0100);
      tick();
      set(ADDI_RT8, LW_R8, NOP, 1, 0, 0);
      chk("lu_rt_addi", ctl, 8'b1111_0000);
      tick();
      set(ADD_R0, LW_R0, NOP, 1, 0, 0);
      chk("lu_r0", ctl, 8'b1111_0000);
      tick();
      set(ADD_R8, LW_R8, NOP, 1, 0, 1);
      chk("lu_over_jump", ctl, 8'b0011_0100);
      tick();
      set(NOP, NOP, NOP, 1, 0, 1);
      chk("jump", ctl, 8'b1111_1000);
      tick();
      md_run("mult_len", MULT, 3);
      md_run("div_len", DIV, 11);
      set(NOP, MULT, NOP, 1, 0, 0);
      tick();
      tick();
      set(NOP, MULT, SW, 0, 0, 0);
      repeat (5) begin
         chk("miss_ctl", ctl, 8'b0000_0001);
         tick();
      end
      set(NOP, MULT, NOP, 1, 0, 0);
      chk("miss_md_held", ctl, 8'b0001_0010);
      tick();
      chk("miss_md_done", ctl, 8'b1111_0000);
      tick();
      set(NOP, MULT, NOP, 1, 0, 0);
      tick();
      tick();
      set(NOP, MULT, NOP, 1, 1, 0);
      chk("bt_flush", ctl, 8'b1111_1110);
      tick();
      set(NOP, NOP, NOP, 1, 0, 0);
      chk("bt_md_clear", ctl, 8'b1111_0000);
      tick();
      set(NOP, NOP, LW_R8, 0, 0, 0);
      repeat (TO - 1) tick();
      chk("tmo_before", mem_timeout, 0);
      tick();
      chk("tmo_set", mem_timeout, 1);
      set(NOP, NOP, NOP, 1, 0, 0);
      repeat (3) tick();
      chk("tmo_sticky", mem_timeout, 1);
      set(NOP, MULT, NOP, 1, 0, 0);
      tick();
      rst = 1;
      tick();
      rst = 0;
      set(NOP, NOP, NOP, 1, 0, 0);
      chk("rst_md_ctl", ctl, 8'b1111_0000);
      chk("rst_tmo", mem_timeout, 0);
      chk("rst_md_stalls", stall_cycles, 0);
      set(NOP, NOP, SYSCALL, 1, 1, 0);
      tick();
      set(NOP, NOP, NOP, 1, 0, 0);
      chk("sys_bt_nohalt", halted, 0);
      set(ADD_R8, LW_R8, NOP, 1, 0, 0);
      tick();
      set(NOP, NOP, SYSCALL, 1, 0, 0);
      chk("sys_ctl", ctl, 8'b1111_0000);
      tick();
      set(NOP, NOP, NOP, 1, 0, 0);
      chk("halt_set", halted, 1);
      chk("halt_ctl", ctl, 8'b0000_1111);
      repeat (3) tick();
      chk("halt_stalls", stall_cycles, 1);
      rst = 1;
      tick();
      rst = 0;
      #1;
      chk("halt_rst", halted, 0);
      chk("halt_rst_stalls", stall_cycles, 0);
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
